mdu_seq: RTL and testbench

Parametrised, iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage. It accepts one operation at a time through a start/busy/done handshake. It computes signed/unsigned multiply, multiply-accumulate and divide over WIDTH cycles with a shift-add/restoring datapath. Compared with the single-cycle multiply path, it adds full 2·WIDTH carry-propagating accumulation, division, explicit HI/LO writes and a width parameter.

---
 rtl/mdu_seq.sv | 167 ++++++++++++++++
 tb/tb_mdu_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports: clk, rst (async, active high), start/op/a/b request,
//        busy/done handshake, hi/lo architectural registers.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // op[2:1] selects the operation family
    localparam logic [1:0] K_MUL = 2'b00;
    localparam logic [1:0] K_DIV = 2'b01;
    localparam logic [1:0] K_MAC = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [1:0]         kind_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mb_q;
    logic               neg_q;
    logic               rneg_q;
    logic               dz_q;
    // upper half: partial product / remainder
    // lower half: multiplier / dividend-quotient
    logic [2*WIDTH-1:0] p;

    logic busy_n, done_n;
    logic go, mt, sgn;
    logic [WIDTH-1:0] ma, mb;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     dt;
    logic [WIDTH:0]     ddiff;
    logic               dge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        go  = (state == IDLE) && start && !(op[2] && op[1]);
        mt  = (state == IDLE) && start && op[2] && op[1];
        // MULT, DIV and MADD are the even codes below 6
        sgn = !op[0];
        ma  = (sgn && a[WIDTH-1]) ? -a : a;
        mb  = (sgn && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        addend   = p[0] ? mb_q : {WIDTH{1'b0}};
        msum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mul_next = {msum, p[WIDTH-1:1]};

        dt       = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        ddiff    = dt - {1'b0, mb_q};
        dge      = (dt >= {1'b0, mb_q});
        rem_next = dge ? ddiff[WIDTH-1:0] : dt[WIDTH-1:0];
        div_next = {rem_next, p[WIDTH-2:0], dge};

        prod = neg_q ? -p : p;
        quo  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem  = rneg_q ? -p[2*WIDTH-1:WIDTH]
                      : p[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = CALC;
            CALC:    if (cnt == LAST) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state == FINISH) || mt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            kind_q <= '0;
            a_q    <= '0;
            mb_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            p      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        kind_q <= op[2:1];
                        a_q    <= a;
                        mb_q   <= mb;
                        neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_q <= sgn && a[WIDTH-1];
                        dz_q   <= (b == '0);
                        p      <= {{WIDTH{1'b0}}, ma};
                        cnt    <= '0;
                    end else if (mt) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (kind_q == K_DIV) p <= div_next;
                    else                 p <= mul_next;
                end
                FINISH: begin
                    unique case (kind_q)
                        K_MUL: {hi, lo} <= prod;
                        K_MAC: {hi, lo} <= {hi, lo} + prod;
                        K_DIV: begin
                            // b=0 leaves the dividend in HI, not its magnitude
                            if (dz_q) begin
                                lo <= '1;
                                hi <= a_q;
                            end else begin
                                lo <= quo;
                                hi <= rem;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq at WIDTH=32 and WIDTH=8.
// Reference model uses plain integer arithmetic on HI/LO.
module tb_mdu_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    int nerr = 0;
    int nchk = 0;

    hl_t q0[$];
    hl_t q1[$];
    hl_t mdl[2];

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start0), .op(op0),
        .a(a0), .b(b0), .busy(busy0), .done(done0),
        .hi(hi0), .lo(lo0)
    );

    mdu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start1), .op(op1),
        .a(a1[7:0]), .b(b1[7:0]), .busy(busy1), .done(done1),
        .hi(hi1), .lo(lo1)
    );

    function automatic void chk(string nm, logic [63:0] got,
                                logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    function automatic hl_t ref_op(int w, logic [2:0] o,
                                   logic [31:0] x, logic [31:0] y,
                                   hl_t cur);
        logic [63:0] m1, m2, acc, full;
        longint ua, ub, sa, sb;
        hl_t r;
        m1 = (64'd1 << w) - 64'd1;
        m2 = {64{1'b1}} >> (64 - 2 * w);
        ua = longint'({32'd0, x} & m1);
        ub = longint'({32'd0, y} & m1);
        sa = x[w-1] ? ua - (longint'(1) << w) : ua;
        sb = y[w-1] ? ub - (longint'(1) << w) : ub;
        acc = ({32'd0, cur.hi} << w) | {32'd0, cur.lo};
        full = '0;
        r = cur;
        case (o)
            3'd0: full = 64'(sa * sb);
            3'd1: full = 64'(ua * ub);
            3'd4: full = acc + 64'(sa * sb);
            3'd5: full = acc + 64'(ua * ub);
            3'd2, 3'd3: begin
                if (ub == 0) begin
                    r.lo = 32'(m1);
                    r.hi = 32'(ua);
                end else if (o == 3'd2) begin
                    r.lo = 32'(64'(sa / sb) & m1);
                    r.hi = 32'(64'(sa % sb) & m1);
                end else begin
                    r.lo = 32'(64'(ua / ub) & m1);
                    r.hi = 32'(64'(ua % ub) & m1);
                end
            end
            3'd6: r.hi = 32'(ua);
            default: r.lo = 32'(ua);
        endcase
        if (o == 3'd0 || o == 3'd1 || o == 3'd4 || o == 3'd5) begin
            full = full & m2;
            r.lo = 32'(full & m1);
            r.hi = 32'((full >> w) & m1);
        end
        return r;
    endfunction

    function automatic logic busy_of(int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(int d);
        return (d == 0) ? done0 : done1;
    endfunction

    function automatic logic [63:0] hilo_of(int d);
        return (d == 0) ? {hi0, lo0} : {24'd0, hi1, 24'd0, lo1};
    endfunction

    task automatic drive(input int d, input logic s, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
        if (d == 0) begin
            start0 = s; op0 = o; a0 = x; b0 = y;
        end else begin
            start1 = s; op1 = o; a1 = x; b1 = y;
        end
    endtask

    task automatic push_exp(input int d, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y);
        hl_t e;
        e = ref_op((d == 0) ? 32 : 8, o, x, y, mdl[d]);
        mdl[d] = e;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the done edge.
    task automatic run(input int d, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
        int n, nb, w, expn;
        w = (d == 0) ? 32 : 8;
        n = 0;
        while (busy_of(d) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        push_exp(d, o, x, y);
        drive(d, 1'b1, o, x, y);
        @(posedge clk); #1;
        if (!hold) drive(d, 1'b0, o, x, y);
        n = 0;
        nb = busy_of(d) ? 1 : 0;
        while (!done_of(d) && n < 200) begin
            if (hold)
                drive(d, 1'b1, 3'($urandom_range(0, 7)),
                      $urandom, $urandom);
            @(posedge clk); #1;
            n++;
            if (busy_of(d)) nb++;
        end
        expn = (o >= 3'd6) ? 0 : w + 1;
        chk($sformatf("latency w%0d op%0d", w, o), 64'(n), 64'(expn));
        chk($sformatf("busy_cycles w%0d op%0d", w, o), 64'(nb),
            64'(expn));
    endtask

    task automatic rand_op(input int d);
        logic [2:0]  o;
        logic [31:0] x, y;
        o = 3'($urandom_range(0, 7));
        x = $urandom;
        case ($urandom_range(0, 3))
            0: y = $urandom;
            1: y = 32'($urandom_range(0, 15));
            2: y = 32'd0;
            default: y = 32'hFFFFFFFF;
        endcase
        run(d, o, x, y, 1'b0);
    endtask

    always @(negedge clk) begin
        hl_t e;
        if (!rst && done0) begin
            if (q0.size() == 0) begin
                chk("w32 unexpected_done", 64'(1), 64'(0));
            end else begin
                e = q0.pop_front();
                chk("w32 hilo", {hi0, lo0}, e);
            end
        end
    end

    always @(negedge clk) begin
        hl_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                chk("w8 unexpected_done", 64'(1), 64'(0));
            end else begin
                e = q1.pop_front();
                chk("w8 hilo", {24'd0, hi1, 24'd0, lo1}, e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        mdl[0] = '0;
        mdl[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset w32", {busy0, done0, hi0, lo0}, 66'd0);
        chk("reset w8", {busy1, done1, hi1, lo1}, 18'd0);
        rst = 1'b0;

        run(0, 3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult -3*5", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFF1);

        run(0, 3'd7, 32'hFFFFFFFF, 32'd0, 1'b0);
        run(0, 3'd6, 32'h00000000, 32'd0, 1'b0);
        run(0, 3'd5, 32'd1, 32'd1, 1'b0);
        chk("maddu carry", {hi0, lo0}, 64'h00000001_00000000);
        run(0, 3'd4, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("madd -1", {hi0, lo0}, 64'h00000000_FFFFFFFF);

        run(0, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div -7/2", {hi0, lo0}, 64'hFFFFFFFF_FFFFFFFD);
        run(0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div min/-1", {hi0, lo0}, 64'h00000000_80000000);
        run(0, 3'd3, 32'h00001234, 32'd0, 1'b0);
        chk("divu by 0", {hi0, lo0}, 64'h00001234_FFFFFFFF);
        run(0, 3'd2, 32'h80000005, 32'd0, 1'b0);
        chk("div by 0", {hi0, lo0}, 64'h80000005_FFFFFFFF);

        run(0, 3'd1, 32'd7, 32'd9, 1'b1);
        chk("multu held start", {hi0, lo0}, 64'h00000000_0000003F);
        run(0, 3'd5, 32'd2, 32'd3, 1'b0);
        chk("maddu in done cycle", {hi0, lo0}, 64'h00000000_00000045);

        for (int i = 0; i < 40; i++) rand_op(0);

        run(0, 3'd6, 32'h00005A5A, 32'd0, 1'b0);
        run(1, 3'd7, 32'h000000A5, 32'd0, 1'b0);
        drive(0, 1'b1, 3'd0, 32'h12345678, 32'h9ABCDEF0);
        @(posedge clk); #1;
        drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset w32", {busy0, done0, hi0, lo0}, 66'd0);
        chk("async reset w8", {busy1, done1, hi1, lo1}, 18'd0);
        q0.delete();
        q1.delete();
        mdl[0] = '0;
        mdl[1] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done0 || busy0) nd++;
        end
        chk("no commit after abort", 64'(nd), 64'd0);
        chk("hilo after abort", {hi0, lo0}, 64'd0);

        run(1, 3'd1, 32'hFF, 32'hFF, 1'b0);
        chk("w8 multu ff*ff", hilo_of(1), 64'h000000FE_00000001);
        run(1, 3'd2, 32'h80, 32'hFF, 1'b0);
        chk("w8 div min/-1", hilo_of(1), 64'h00000000_00000080);
        for (int i = 0; i < 30; i++) rand_op(1);

        repeat (3) @(posedge clk);
        #1;
        chk("w32 queue drained", 64'(q0.size()), 64'd0);
        chk("w8 queue drained", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
